// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Stage entries are sized for the full RV32 register file index.
package pipe_hazard_pkg;

    localparam int         REG_AW_MAX = 5;
    localparam logic [2:0] FWD_RF     = 3'd0;

    typedef struct packed {
        logic                  vld;
        logic [REG_AW_MAX-1:0] rs1;
        logic                  rs1_used;
        logic [REG_AW_MAX-1:0] rs2;
        logic                  rs2_used;
        logic [REG_AW_MAX-1:0] rd;
        logic                  we;
        logic                  load;
    } stage_entry_t;

    // True when a live producer writes the register a consumer actually reads (x0 never matches).
    function automatic logic idx_match(
        input logic [REG_AW_MAX-1:0] rd,
        input logic                  we,
        input logic                  vld,
        input logic [REG_AW_MAX-1:0] rs,
        input logic                  used
    );
        return vld & we & used & (rs != '0) & (rd == rs);
    endfunction

endpackage

// File: rtl/pipe_fwd_select.sv
// Priority picker for one EX operand: returns the youngest matching stage index
// (1..N), or FWD_RF when no tracked stage produces the operand.
module pipe_fwd_select
    import pipe_hazard_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N:1] match_i,
    output logic [2:0] sel_o
);

    // NOTE: blocking assignments in always_comb; the last write wins, so scanning
    // from the oldest stage down to stage 1 leaves the youngest producer selected.
    always_comb begin
        sel_o = FWD_RF;
        for (int k = N; k >= 1; k--) begin
            if (match_i[k]) begin
                sel_o = 3'(k);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: tracks in-flight destinations from EX to WB and drives
// load-use stall, EX forward selects and ID bypass. Define HAZARD_PERF_EN for perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW         = 5,
    parameter int PIPE_DEPTH     = 3,
    parameter int LOAD_READY_STG = 2,
    parameter int FLUSH_STAGES   = 1,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold_i,
    input  logic                  flush_i,
    input  logic                  id_valid_i,
    input  logic [REG_AW-1:0]     id_rs1_i,
    input  logic                  id_rs1_used_i,
    input  logic [REG_AW-1:0]     id_rs2_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_AW-1:0]     id_rd_i,
    input  logic                  id_we_i,
    input  logic                  id_load_i,
    output logic                  stall_o,
    output logic                  id_advance_o,
    output logic                  id_byp1_o,
    output logic                  id_byp2_o,
    output logic [2:0]            ex_fwd1_o,
    output logic [2:0]            ex_fwd2_o,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
`endif
    output logic [PIPE_DEPTH-1:0] stage_vld_o
);

    if (PIPE_DEPTH < 2 || PIPE_DEPTH > 6 || LOAD_READY_STG < 1 ||
        LOAD_READY_STG > PIPE_DEPTH - 1 || FLUSH_STAGES < 0 ||
        FLUSH_STAGES > PIPE_DEPTH - 1 || REG_AW < 1 || REG_AW > REG_AW_MAX ||
        CNT_W < 1) begin : g_bad_params
        $error("pipe_hazard_ctrl: parameter out of range");
    end

    stage_entry_t              stage_q [PIPE_DEPTH];
    stage_entry_t              stage_d [PIPE_DEPTH];
    stage_entry_t              id_entry;
    stage_entry_t              wb_entry;
    logic                      load_use;
    logic                      flush_eff;
    logic [PIPE_DEPTH-1:1]     fwd1_match;
    logic [PIPE_DEPTH-1:1]     fwd2_match;
    logic [2:0]                fwd1_sel;
    logic [2:0]                fwd2_sel;
    logic                      fwd_early_load;

    // Writes to x0 are captured as non-writing so they never stall, forward or bypass.
    always_comb begin
        id_entry          = '0;
        id_entry.vld      = 1'b1;
        id_entry.rs1      = REG_AW_MAX'(id_rs1_i);
        id_entry.rs1_used = id_rs1_used_i;
        id_entry.rs2      = REG_AW_MAX'(id_rs2_i);
        id_entry.rs2_used = id_rs2_used_i;
        id_entry.rd       = REG_AW_MAX'(id_rd_i);
        id_entry.we       = id_we_i & (id_rd_i != '0);
        id_entry.load     = id_load_i;
    end

    // NOTE: every always_comb output gets a default before any conditional write,
    // otherwise the untaken path would infer a latch.
    always_comb begin
        load_use = 1'b0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if ((k + 1 < LOAD_READY_STG) && stage_q[k].load &&
                (idx_match(stage_q[k].rd, stage_q[k].we, stage_q[k].vld, id_entry.rs1, id_rs1_used_i) ||
                 idx_match(stage_q[k].rd, stage_q[k].we, stage_q[k].vld, id_entry.rs2, id_rs2_used_i))) begin
                load_use = 1'b1;
            end
        end
    end

    assign flush_eff    = flush_i & ~hold_i;
    assign stall_o      = ~rst & id_valid_i & load_use & ~flush_eff;
    assign id_advance_o = ~rst & id_valid_i & ~stall_o & ~hold_i & ~flush_i;

    always_comb begin
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (!hold_i) begin
            stage_d[0] = id_advance_o ? id_entry : '0;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            if (flush_i) begin
                for (int k = 0; k < FLUSH_STAGES; k++) begin
                    stage_d[k] = '0;
                end
            end
        end
    end

    // NOTE: the stage array is control state, not a data memory; every entry is
    // reset so stale valid bits cannot raise stalls or forwards after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    always_comb begin
        fwd1_match = '0;
        fwd2_match = '0;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            fwd1_match[k] = stage_q[0].vld &
                            idx_match(stage_q[k].rd, stage_q[k].we, stage_q[k].vld,
                                      stage_q[0].rs1, stage_q[0].rs1_used);
            fwd2_match[k] = stage_q[0].vld &
                            idx_match(stage_q[k].rd, stage_q[k].we, stage_q[k].vld,
                                      stage_q[0].rs2, stage_q[0].rs2_used);
        end
    end

    pipe_fwd_select #(.N(PIPE_DEPTH - 1)) u_fwd1 (
        .match_i (fwd1_match),
        .sel_o   (fwd1_sel)
    );

    pipe_fwd_select #(.N(PIPE_DEPTH - 1)) u_fwd2 (
        .match_i (fwd2_match),
        .sel_o   (fwd2_sel)
    );

    assign ex_fwd1_o = rst ? FWD_RF : fwd1_sel;
    assign ex_fwd2_o = rst ? FWD_RF : fwd2_sel;

    // The WB entry writes the regfile this cycle; ID reads the write data directly.
    assign wb_entry  = stage_q[PIPE_DEPTH-1];
    assign id_byp1_o = ~rst & id_valid_i & wb_entry.vld & wb_entry.we &
                       (id_entry.rs1 != '0) & (wb_entry.rd == id_entry.rs1);
    assign id_byp2_o = ~rst & id_valid_i & wb_entry.vld & wb_entry.we &
                       (id_entry.rs2 != '0) & (wb_entry.rd == id_entry.rs2);

    always_comb begin
        stage_vld_o = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            stage_vld_o[k] = stage_q[k].vld;
        end
    end

    always_comb begin
        fwd_early_load = 1'b0;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            if ((fwd1_sel == 3'(k) || fwd2_sel == 3'(k)) && stage_q[k].load &&
                (k < LOAD_READY_STG)) begin
                fwd_early_load = 1'b1;
            end
        end
    end

    a_no_early_load_fwd : assert property (@(posedge clk) disable iff (rst) !fwd_early_load);

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_o && !hold_i) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_eff) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a default-parameter instance and a deep
// instance (PIPE_DEPTH=5, LOAD_READY_STG=3, FLUSH_STAGES=2) driven by directed vectors.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       hold;
        logic       flush;
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       load;
    } in_t;

    typedef enum int {F_STALL, F_ADV, F_FWD1, F_FWD2, F_BYP1, F_BYP2, F_VLD, F_SCNT, F_FCNT} field_e;

    typedef struct {
        string       name;
        int          dut;
        field_e      field;
        int unsigned want;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    in_t  ia;
    in_t  ib;
    int   cur;
    int   passed = 0;
    int   total  = 0;
    exp_t sb[$];

    logic       a_stall, a_adv, a_byp1, a_byp2;
    logic [2:0] a_fwd1, a_fwd2;
    logic [2:0] a_vld;
    logic       b_stall, b_adv, b_byp1, b_byp2;
    logic [2:0] b_fwd1, b_fwd2;
    logic [4:0] b_vld;
`ifdef HAZARD_PERF_EN
    logic [31:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut_a (
        .clk           (clk),
        .rst           (rst),
        .hold_i        (ia.hold),
        .flush_i       (ia.flush),
        .id_valid_i    (ia.valid),
        .id_rs1_i      (ia.rs1),
        .id_rs1_used_i (ia.u1),
        .id_rs2_i      (ia.rs2),
        .id_rs2_used_i (ia.u2),
        .id_rd_i       (ia.rd),
        .id_we_i       (ia.we),
        .id_load_i     (ia.load),
        .stall_o       (a_stall),
        .id_advance_o  (a_adv),
        .id_byp1_o     (a_byp1),
        .id_byp2_o     (a_byp2),
        .ex_fwd1_o     (a_fwd1),
        .ex_fwd2_o     (a_fwd2),
`ifdef HAZARD_PERF_EN
        .stall_cnt_o   (a_scnt),
        .flush_cnt_o   (a_fcnt),
`endif
        .stage_vld_o   (a_vld)
    );

    pipe_hazard_ctrl #(
        .PIPE_DEPTH     (5),
        .LOAD_READY_STG (3),
        .FLUSH_STAGES   (2)
    ) dut_b (
        .clk           (clk),
        .rst           (rst),
        .hold_i        (ib.hold),
        .flush_i       (ib.flush),
        .id_valid_i    (ib.valid),
        .id_rs1_i      (ib.rs1),
        .id_rs1_used_i (ib.u1),
        .id_rs2_i      (ib.rs2),
        .id_rs2_used_i (ib.u2),
        .id_rd_i       (ib.rd),
        .id_we_i       (ib.we),
        .id_load_i     (ib.load),
        .stall_o       (b_stall),
        .id_advance_o  (b_adv),
        .id_byp1_o     (b_byp1),
        .id_byp2_o     (b_byp2),
        .ex_fwd1_o     (b_fwd1),
        .ex_fwd2_o     (b_fwd2),
`ifdef HAZARD_PERF_EN
        .stall_cnt_o   (b_scnt),
        .flush_cnt_o   (b_fcnt),
`endif
        .stage_vld_o   (b_vld)
    );

    function automatic in_t alu(input int rd, input int rs1, input int rs2);
        in_t v = '0;
        v.valid = 1'b1;
        v.rs1   = 5'(rs1);
        v.u1    = 1'b1;
        v.rs2   = 5'(rs2);
        v.u2    = 1'b1;
        v.rd    = 5'(rd);
        v.we    = 1'b1;
        return v;
    endfunction

    function automatic in_t ld(input int rd, input int rs1);
        in_t v = '0;
        v.valid = 1'b1;
        v.rs1   = 5'(rs1);
        v.u1    = 1'b1;
        v.rd    = 5'(rd);
        v.we    = 1'b1;
        v.load  = 1'b1;
        return v;
    endfunction

    function automatic in_t nop();
        return '0;
    endfunction

    function automatic in_t with_hold(input in_t v);
        in_t r = v;
        r.hold = 1'b1;
        return r;
    endfunction

    function automatic in_t with_flush(input in_t v);
        in_t r = v;
        r.flush = 1'b1;
        return r;
    endfunction

    // Advance one clock and present new ID-side inputs to the selected instance.
    task automatic cyc(input in_t v);
        @(posedge clk);
        #1;
        if (cur == 0) ia = v;
        else          ib = v;
    endtask

    task automatic chk(input string name, input field_e f, input int unsigned want);
        exp_t e;
        e.name  = name;
        e.dut   = cur;
        e.field = f;
        e.want  = want;
        sb.push_back(e);
    endtask

    function automatic int unsigned actual(input int dut, input field_e f);
        case (f)
            F_STALL: return (dut == 0) ? 32'(a_stall) : 32'(b_stall);
            F_ADV:   return (dut == 0) ? 32'(a_adv)   : 32'(b_adv);
            F_FWD1:  return (dut == 0) ? 32'(a_fwd1)  : 32'(b_fwd1);
            F_FWD2:  return (dut == 0) ? 32'(a_fwd2)  : 32'(b_fwd2);
            F_BYP1:  return (dut == 0) ? 32'(a_byp1)  : 32'(b_byp1);
            F_BYP2:  return (dut == 0) ? 32'(a_byp2)  : 32'(b_byp2);
            F_VLD:   return (dut == 0) ? 32'(a_vld)   : 32'(b_vld);
`ifdef HAZARD_PERF_EN
            F_SCNT:  return (dut == 0) ? a_scnt : b_scnt;
            F_FCNT:  return (dut == 0) ? a_fcnt : b_fcnt;
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: outputs are combinational every cycle, so expectations queued
    // after the active edge are compared at the following falling edge.
    always @(negedge clk) begin
        exp_t        e;
        int unsigned act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = actual(e.dut, e.field);
            total++;
            if (act === e.want) passed++;
            else $display("FAIL %s (dut %0d): got %0d, expected %0d", e.name, e.dut, act, e.want);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cur = 0;
        rst = 1'b1;
        ia  = alu(6, 5, 1);
        ib  = alu(6, 5, 1);
        @(posedge clk);
        #1;
        cur = 0;
        chk("rst_stall", F_STALL, 0);
        chk("rst_adv",   F_ADV,   0);
        chk("rst_vld",   F_VLD,   0);
        chk("rst_fwd1",  F_FWD1,  0);
        chk("rst_byp1",  F_BYP1,  0);
        cur = 1;
        chk("rst_vld",   F_VLD,   0);
        chk("rst_adv",   F_ADV,   0);
`ifdef HAZARD_PERF_EN
        chk("rst_scnt",  F_SCNT,  0);
`endif
        cur = 0;

        // Load-use on the default pipe: one stall, bubble, then forward from stage 2.
        cyc(ld(5, 2)); rst = 1'b0; ib = nop();
        chk("t1_adv_load", F_ADV, 1);
        chk("t1_nostall", F_STALL, 0);
        cyc(alu(6, 5, 1));
        chk("t1_stall", F_STALL, 1);
        chk("t1_noadv", F_ADV, 0);
        chk("t1_vld_ld", F_VLD, 3'b001);
        cyc(alu(6, 5, 1));
        chk("t1_release", F_STALL, 0);
        chk("t1_adv", F_ADV, 1);
        chk("t1_bubble", F_VLD, 3'b010);
        cyc(nop());
        chk("t1_vld", F_VLD, 3'b101);
        chk("t1_fwd1", F_FWD1, 2);
        chk("t1_fwd2", F_FWD2, 0);
        cyc(nop());
        chk("t1_drain1", F_VLD, 3'b010);
        cyc(nop());
        chk("t1_drain2", F_VLD, 3'b100);

        // ALU producers at distance 1, 2 and 3 (bypass), then youngest-wins.
        cyc(alu(5, 1, 2));
        chk("t2_empty", F_VLD, 0);
        chk("t2_adv", F_ADV, 1);
        cyc(alu(7, 5, 5));
        chk("t2_nostall", F_STALL, 0);
        chk("t2_adv_c1", F_ADV, 1);
        cyc(alu(11, 3, 4));
        chk("t2_fwd1_d1", F_FWD1, 1);
        chk("t2_fwd2_d1", F_FWD2, 1);
        chk("t2_vld_c9", F_VLD, 3'b011);
        cyc(nop());
        chk("t2_nofwd", F_FWD1, 0);
        chk("t2_vld_full", F_VLD, 3'b111);
        cyc(alu(12, 11, 11));
        chk("t2_nobyp", F_BYP1, 0);
        cyc(alu(13, 4, 4));
        chk("t2_fwd1_d2", F_FWD1, 2);
        chk("t2_fwd2_d2", F_FWD2, 2);
        chk("t2_vld_c12", F_VLD, 3'b101);
        cyc(nop());
        cyc(nop());
        chk("t2_vld_c14", F_VLD, 3'b110);
        cyc(alu(14, 13, 13));
        chk("t2_byp1", F_BYP1, 1);
        chk("t2_byp2", F_BYP2, 1);
        chk("t2_vld_c15", F_VLD, 3'b100);
        cyc(alu(20, 1, 1));
        chk("t2_retired", F_FWD1, 0);
        cyc(alu(20, 2, 2));
        cyc(alu(21, 20, 1));
        cyc(nop());
        chk("t2_youngest", F_FWD1, 1);
        chk("t2_young_rs2", F_FWD2, 0);
        chk("t2_vld_c19", F_VLD, 3'b111);

        // x0 writers and a load to x0 never create hazards.
        cyc(alu(0, 1, 2));
        cyc(ld(0, 3));
        cyc(alu(22, 0, 0));
        chk("t3_nostall", F_STALL, 0);
        chk("t3_adv", F_ADV, 1);
        cyc(nop());
        chk("t3_fwd1", F_FWD1, 0);
        chk("t3_fwd2", F_FWD2, 0);
        cyc(alu(23, 0, 0));
        chk("t3_byp1", F_BYP1, 0);
        chk("t3_byp2", F_BYP2, 0);

        // Flush coincident with a load-use stall (one flushed stage).
        cyc(ld(5, 2));
        chk("t4_adv_ld", F_ADV, 1);
        cyc(with_flush(alu(6, 5, 1)));
        chk("t4_stall", F_STALL, 0);
        chk("t4_adv", F_ADV, 0);
        chk("t4_vld_pre", F_VLD, 3'b011);
        cyc(nop());
        chk("t4_vld_post", F_VLD, 3'b110);
        cyc(nop());
        chk("t4_drain", F_VLD, 3'b100);

        // Three-cycle hold mid-sequence, then hold together with flush.
        cyc(alu(5, 1, 2));
        chk("t5_empty", F_VLD, 0);
        cyc(alu(7, 5, 6));
        chk("t5_vld_p", F_VLD, 3'b001);
        for (int i = 0; i < 3; i++) begin
            cyc(with_hold(alu(8, 1, 1)));
            chk($sformatf("t5_hold%0d_vld", i), F_VLD, 3'b011);
            chk($sformatf("t5_hold%0d_fwd1", i), F_FWD1, 1);
            chk($sformatf("t5_hold%0d_adv", i), F_ADV, 0);
        end
        cyc(alu(8, 1, 1));
        chk("t5_resume_vld", F_VLD, 3'b011);
        chk("t5_resume_fwd1", F_FWD1, 1);
        chk("t5_resume_adv", F_ADV, 1);
        cyc(nop());
        chk("t5_after_vld", F_VLD, 3'b111);
        chk("t5_after_fwd1", F_FWD1, 0);
        cyc(with_flush(with_hold(nop())));
        chk("t5_hf_vld", F_VLD, 3'b110);
        cyc(nop());
        chk("t5_hf_frozen", F_VLD, 3'b110);
        cyc(nop());
        chk("t5_hf_shift", F_VLD, 3'b100);
        cyc(nop());

        // Deep pipe: two stall cycles, forward from stage 3, two-stage flush, reset mid-stall.
        cur = 1;
        cyc(ld(5, 2));
        chk("t6_adv_ld", F_ADV, 1);
        chk("t6_vld0", F_VLD, 0);
        cyc(alu(6, 5, 1));
        chk("t6_stall1", F_STALL, 1);
        chk("t6_noadv1", F_ADV, 0);
        chk("t6_vld1", F_VLD, 5'b00001);
        cyc(alu(6, 5, 1));
        chk("t6_stall2", F_STALL, 1);
        chk("t6_vld2", F_VLD, 5'b00010);
        cyc(alu(6, 5, 1));
        chk("t6_release", F_STALL, 0);
        chk("t6_adv", F_ADV, 1);
        chk("t6_vld3", F_VLD, 5'b00100);
        cyc(nop());
        chk("t6_fwd1", F_FWD1, 3);
        chk("t6_vld4", F_VLD, 5'b01001);
`ifdef HAZARD_PERF_EN
        chk("t6_scnt", F_SCNT, 2);
`endif
        cyc(alu(7, 1, 1));
        chk("t6_vld5", F_VLD, 5'b10010);
        chk("t6_adv7", F_ADV, 1);
        cyc(with_flush(alu(8, 2, 2)));
        chk("t6_fl_stall", F_STALL, 0);
        chk("t6_fl_adv", F_ADV, 0);
        chk("t6_fl_pre", F_VLD, 5'b00101);
        cyc(ld(9, 3));
        chk("t6_fl_post", F_VLD, 5'b01000);
        chk("t6_adv9", F_ADV, 1);
`ifdef HAZARD_PERF_EN
        chk("t6_fcnt", F_FCNT, 1);
`endif
        cyc(alu(10, 9, 9));
        chk("t6_stall_pre_rst", F_STALL, 1);
        chk("t6_vld_pre_rst", F_VLD, 5'b10001);
        cyc(alu(10, 9, 9)); rst = 1'b1;
        cyc(alu(10, 9, 9)); rst = 1'b0;
        chk("t6_rst_stall", F_STALL, 0);
        chk("t6_rst_vld", F_VLD, 0);
        chk("t6_rst_fwd1", F_FWD1, 0);
        chk("t6_rst_fwd2", F_FWD2, 0);
        chk("t6_rst_byp1", F_BYP1, 0);
        chk("t6_rst_byp2", F_BYP2, 0);
        chk("t6_rst_adv", F_ADV, 1);
`ifdef HAZARD_PERF_EN
        chk("t6_rst_scnt", F_SCNT, 0);
        chk("t6_rst_fcnt", F_FCNT, 0);
`endif
        cyc(nop());

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            $display("FAIL %0d expectations were never compared", sb.size());
        end
        if (total < 12) begin
            $display("FAIL only %0d checks executed", total);
        end
        if (passed == total && sb.size() == 0 && total >= 12) begin
            $display("PASS %0d/%0d checks passed", passed, total);
        end else begin
            $display("FAIL %0d/%0d checks passed", passed, total);
        end
        $finish;
    end

endmodule
